fft_frame_sequencer: RTL and testbench
======================================

Name: fft_frame_sequencer

Overview:
Sequences the Xilinx FFT core inside the spectrum analyzer PL datapath. It issues the FFT configuration word and gates the sample stream into frames of 2^nfft_log2 samples with a correct tlast. It tracks outstanding frames against FFT result frames and reports status and errors to the PS-side control registers. It runs single-shot or continuous acquisition.

Parameters:
DATA_W, 32, sample/FFT input data width
MAX_OUTSTANDING, 4, maximum frames sent to the FFT but not yet returned
DRAIN_TIMEOUT, 65536, cycles allowed in DRAIN before timeout_err

Ports:
ps_clk  in  1  PL clock from PS
ps_aresetn  in  1  asynchronous active-low reset
start  in  1  pulse; begins acquisition
stop  in  1  pulse; ends acquisition after the current frame
continuous  in  1  level; repeat frames until stop
nfft_log2  in  5  transform size log2, valid 3..12, sampled at accepted start
fwd_inv  in  1  1=forward, sampled at accepted start
s_axis_tdata  in  DATA_W  input samples
s_axis_tvalid  in  1
s_axis_tready  out  1
m_axis_data_tdata  out  DATA_W  to FFT data input
m_axis_data_tvalid  out  1
m_axis_data_tready  in  1
m_axis_data_tlast  out  1
m_axis_cfg_tdata  out  16  to FFT config channel
m_axis_cfg_tvalid  out  1
m_axis_cfg_tready  in  1
res_tvalid  in  1  tap of FFT result handshake
res_tready  in  1
res_tlast  in  1
ev_tlast_unexpected  in  1  FFT event
ev_tlast_missing  in  1  FFT event
busy  out  1  high when state != IDLE
done  out  1  one-cycle pulse on return to IDLE
frame_cnt  out  32  result frames completed since last accepted start
cfg_err  out  1  sticky; invalid nfft_log2 at start
seq_err  out  1  sticky; an FFT tlast event was seen
timeout_err  out  1  sticky; DRAIN timed out

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0; stop_pending 0.
- Every counter and flag is registered. Data passthrough is combinational (zero latency).
- IDLE:
  - start with nfft_log2 in 3..12: latch N=2^nfft_log2 and fwd_inv; clear frame_cnt, cfg_err, seq_err, timeout_err; go to CFG.
  - start with nfft_log2 outside 3..12: set cfg_err, stay in IDLE, no done pulse.
- CFG:
  - m_axis_cfg_tvalid=1 and m_axis_cfg_tdata={7'b0, fwd_inv, 3'b0, nfft_log2}.
  - tdata and tvalid stay stable until tready. Go to STREAM on handshake.
  - If stop_pending is set at the handshake, go to DRAIN instead.
- STREAM:
  - Gate open condition: not (sample_cnt==0 and outstanding==MAX_OUTSTANDING).
  - Gate open: m_axis_data_tvalid=s_axis_tvalid, s_axis_tready=m_axis_data_tready, tdata passes through. Gate closed: both deasserted.
  - In every other state, s_axis_tready=0 and m_axis_data_tvalid=0.
  - sample_cnt increments per data handshake. m_axis_data_tlast=(sample_cnt==N-1).
  - On the last handshake: sample_cnt←0 and outstanding+1. Then stay in STREAM if continuous=1 and stop_pending=0, otherwise go to DRAIN.
  - A frame is never truncated.
- DRAIN:
  - Wait for outstanding==0, then go to IDLE and pulse done.
  - Drain counter starts at DRAIN_TIMEOUT on entry. On expiry, set timeout_err, go to IDLE, and pulse done. outstanding is reset to 0 on timeout.
- stop:
  - In CFG or STREAM, sets stop_pending.
  - Ignored in IDLE and DRAIN.
  - stop_pending clears on entry to IDLE.
- start while busy: ignored.
- Result tracking: a result frame completes on res_tvalid&res_tready&res_tlast, in any state. It decrements outstanding, floored at 0, and increments frame_cnt.
- Simultaneous increment and decrement of outstanding: no net change.
- ev_tlast_unexpected or ev_tlast_missing sets seq_err in any state. Sequencing continues.
- frame_cnt wraps modulo 2^32.
- Asynchronous reset mid-frame: immediate return to reset values. Partial frames already inside the FFT are not tracked.

Test Plan:
- Single shot: start, nfft_log2=6, fwd_inv=1, continuous=0, continuous valid samples → cfg tdata=0x0106, 64 data beats with tlast only on beat 63, busy=1; after one result tlast, done pulses once and frame_cnt=1.
- Invalid size: start with nfft_log2=13 → cfg_err=1, busy stays 0, no cfg tvalid; a following start with nfft_log2=3 clears cfg_err.
- Continuous with backpressure: nfft_log2=3, random m_axis_data_tready, results withheld → exactly 4 frames of 8 beats are passed, then s_axis_tready=0 until a result tlast arrives.
- Stop mid-frame: stop asserted at beat 10 of 16, continuous=1 → beats 11–15 complete with tlast on 15, no further frames, done after outstanding returns to 0.
- Timeout and events: DRAIN_TIMEOUT=100, no results returned → timeout_err=1 and done fires 100 cycles after DRAIN entry; an ev_tlast_missing pulse sets seq_err=1.
- Reset during STREAM at beat 5 → all outputs 0 and state IDLE asynchronously; a new start runs a clean frame.

Source files
------------

// File: rtl/fft_frame_sequencer.sv
// Sequences the FFT core: issues the config word, gates input samples into
// 2^nfft_log2 frames with tlast, and tracks frames outstanding inside the FFT.
module fft_frame_sequencer #(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned DRAIN_TIMEOUT   = 65536
) (
  input  logic              ps_clk,
  input  logic              ps_aresetn,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic [4:0]        nfft_log2,
  input  logic              fwd_inv,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_data_tdata,
  output logic              m_axis_data_tvalid,
  input  logic              m_axis_data_tready,
  output logic              m_axis_data_tlast,
  output logic [15:0]       m_axis_cfg_tdata,
  output logic              m_axis_cfg_tvalid,
  input  logic              m_axis_cfg_tready,
  input  logic              res_tvalid,
  input  logic              res_tready,
  input  logic              res_tlast,
  input  logic              ev_tlast_unexpected,
  input  logic              ev_tlast_missing,
  output logic              busy,
  output logic              done,
  output logic [31:0]       frame_cnt,
  output logic              cfg_err,
  output logic              seq_err,
  output logic              timeout_err
);

  localparam int unsigned CNT_W = 12;
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned DRN_W = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_CFG, S_STREAM, S_DRAIN} state_t;

  state_t             state, state_n;
  logic [4:0]         nfft_q;
  logic               fwd_q;
  logic [CNT_W-1:0]   n_m1_q;
  logic [CNT_W-1:0]   sample_cnt;
  logic [OUT_W-1:0]   outstanding;
  logic [DRN_W-1:0]   drain_cnt;
  logic               stop_pending;

  logic size_ok, start_ok, start_bad;
  logic gate_open, data_hs, last_hs, res_done;
  logic timeout_hit;

  assign size_ok   = (nfft_log2 >= 5'd3) && (nfft_log2 <= 5'd12);
  assign start_ok  = (state == S_IDLE) && start && size_ok;
  assign start_bad = (state == S_IDLE) && start && !size_ok;

  // A new frame may not begin while the FFT already holds the maximum.
  assign gate_open = (state == S_STREAM) &&
                     !((sample_cnt == '0) && (outstanding == OUT_W'(MAX_OUTSTANDING)));
  assign data_hs   = gate_open && s_axis_tvalid && m_axis_data_tready;
  assign last_hs   = data_hs && (sample_cnt == n_m1_q);
  assign res_done  = res_tvalid && res_tready && res_tlast;

  assign s_axis_tready      = gate_open && m_axis_data_tready;
  assign m_axis_data_tvalid = gate_open && s_axis_tvalid;
  assign m_axis_data_tdata  = gate_open ? s_axis_tdata : '0;
  assign m_axis_data_tlast  = gate_open && (sample_cnt == n_m1_q);
  assign m_axis_cfg_tvalid  = (state == S_CFG);
  assign m_axis_cfg_tdata   = (state == S_CFG) ? {7'b0, fwd_q, 3'b0, nfft_q} : 16'h0000;
  assign busy               = (state != S_IDLE);

  // Next-state logic
  always_comb begin
    state_n     = state;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE:   if (start_ok) state_n = S_CFG;
      S_CFG:    if (m_axis_cfg_tready) state_n = stop_pending ? S_DRAIN : S_STREAM;
      S_STREAM: if (last_hs) state_n = (continuous && !stop_pending && !stop) ? S_STREAM : S_DRAIN;
      S_DRAIN: begin
        if (outstanding == '0) begin
          state_n = S_IDLE;
        end else if (drain_cnt <= DRN_W'(1)) begin
          state_n     = S_IDLE;
          timeout_hit = 1'b1;
        end
      end
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge ps_clk or negedge ps_aresetn) begin
    if (!ps_aresetn) begin
      state        <= S_IDLE;
      nfft_q       <= 5'd0;
      fwd_q        <= 1'b0;
      n_m1_q       <= '0;
      sample_cnt   <= '0;
      outstanding  <= '0;
      drain_cnt    <= '0;
      stop_pending <= 1'b0;
      done         <= 1'b0;
      frame_cnt    <= 32'd0;
      cfg_err      <= 1'b0;
      seq_err      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state <= state_n;
      done  <= (state != S_IDLE) && (state_n == S_IDLE);

      if (start_ok) begin
        nfft_q <= nfft_log2;
        fwd_q  <= fwd_inv;
        n_m1_q <= CNT_W'((13'd1 << nfft_log2) - 13'd1);
      end

      if (last_hs)      sample_cnt <= '0;
      else if (data_hs) sample_cnt <= sample_cnt + CNT_W'(1);

      // Sent and returned in the same cycle cancel out; returns floor at zero.
      if (timeout_hit)                                    outstanding <= '0;
      else if (last_hs && !res_done)                      outstanding <= outstanding + OUT_W'(1);
      else if (!last_hs && res_done && outstanding != '0) outstanding <= outstanding - OUT_W'(1);

      if (state_n == S_DRAIN && state != S_DRAIN) drain_cnt <= DRN_W'(DRAIN_TIMEOUT);
      else if (state == S_DRAIN)                  drain_cnt <= drain_cnt - DRN_W'(1);

      if (state_n == S_IDLE)                                  stop_pending <= 1'b0;
      else if (stop && (state == S_CFG || state == S_STREAM)) stop_pending <= 1'b1;

      if (start_ok)      frame_cnt <= 32'd0;
      else if (res_done) frame_cnt <= frame_cnt + 32'd1;

      if (start_bad)     cfg_err <= 1'b1;
      else if (start_ok) cfg_err <= 1'b0;

      if (ev_tlast_unexpected || ev_tlast_missing) seq_err <= 1'b1;
      else if (start_ok)                           seq_err <= 1'b0;

      if (timeout_hit)   timeout_err <= 1'b1;
      else if (start_ok) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Scoreboard bench for fft_frame_sequencer: expected cfg words and data beats
// are queued by the stimulus and popped by a negedge monitor on each handshake.
module tb_fft_frame_sequencer;

  logic        ps_clk = 1'b0;
  logic        ps_aresetn;
  logic        start, stop, continuous, fwd_inv;
  logic [4:0]  nfft_log2;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready;
  logic [31:0] m_axis_data_tdata;
  logic        m_axis_data_tvalid, m_axis_data_tready, m_axis_data_tlast;
  logic [15:0] m_axis_cfg_tdata;
  logic        m_axis_cfg_tvalid, m_axis_cfg_tready;
  logic        res_tvalid, res_tready, res_tlast;
  logic        ev_tlast_unexpected, ev_tlast_missing;
  logic        busy, done, cfg_err, seq_err, timeout_err;
  logic [31:0] frame_cnt;

  fft_frame_sequencer #(.DATA_W(32), .MAX_OUTSTANDING(4), .DRAIN_TIMEOUT(100)) dut (
    .ps_clk(ps_clk), .ps_aresetn(ps_aresetn), .start(start), .stop(stop),
    .continuous(continuous), .nfft_log2(nfft_log2), .fwd_inv(fwd_inv),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_data_tdata(m_axis_data_tdata), .m_axis_data_tvalid(m_axis_data_tvalid),
    .m_axis_data_tready(m_axis_data_tready), .m_axis_data_tlast(m_axis_data_tlast),
    .m_axis_cfg_tdata(m_axis_cfg_tdata), .m_axis_cfg_tvalid(m_axis_cfg_tvalid),
    .m_axis_cfg_tready(m_axis_cfg_tready), .res_tvalid(res_tvalid), .res_tready(res_tready),
    .res_tlast(res_tlast), .ev_tlast_unexpected(ev_tlast_unexpected),
    .ev_tlast_missing(ev_tlast_missing), .busy(busy), .done(done), .frame_cnt(frame_cnt),
    .cfg_err(cfg_err), .seq_err(seq_err), .timeout_err(timeout_err)
  );

  initial forever #5 ps_clk = ~ps_clk;

  typedef struct packed { logic [31:0] data; logic last; } beat_t;

  beat_t       exp_q[$];
  logic [15:0] cfg_q[$];
  int          errors = 0;
  int          checks = 0;
  int          beats_seen = 0;
  int          done_cnt = 0;
  logic [31:0] src_word = 32'd0;
  logic [31:0] exp_word = 32'd0;
  logic        s_hs_q = 1'b0;
  bit          rand_rdy = 1'b0;

  assign s_axis_tdata = src_word;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every cfg/data handshake.
  always @(negedge ps_clk) begin : mon
    beat_t       b;
    logic [15:0] c;
    s_hs_q = s_axis_tvalid && s_axis_tready;
    if (done) done_cnt++;
    if (m_axis_data_tvalid && m_axis_data_tready) begin
      beats_seen++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL data_unexpected: got beat 0x%0h last=%0b, required no beat",
                 m_axis_data_tdata, m_axis_data_tlast);
      end else begin
        b = exp_q.pop_front();
        check("data_tdata", 64'(m_axis_data_tdata), 64'(b.data));
        check("data_tlast", 64'(m_axis_data_tlast), 64'(b.last));
      end
    end
    if (m_axis_cfg_tvalid && m_axis_cfg_tready) begin
      if (cfg_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL cfg_unexpected: got cfg 0x%0h, required no cfg", m_axis_cfg_tdata);
      end else begin
        c = cfg_q.pop_front();
        check("cfg_tdata", 64'(m_axis_cfg_tdata), 64'(c));
      end
    end
  end

  // Sample source advances after each accepted sample; optional random backpressure.
  always @(posedge ps_clk) begin
    #1;
    if (s_hs_q) src_word = src_word + 32'd1;
    m_axis_data_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge ps_clk); #1;
  endtask

  task automatic sample();
    @(negedge ps_clk); #1;
  endtask

  task automatic push_frames(input int frames, input int n);
    beat_t b;
    for (int f = 0; f < frames; f++)
      for (int i = 0; i < n; i++) begin
        b.data = exp_word;
        b.last = (i == n - 1);
        exp_q.push_back(b);
        exp_word = exp_word + 32'd1;
      end
  endtask

  task automatic do_start(input logic [4:0] n, input logic f);
    tick(); start = 1'b1; nfft_log2 = n; fwd_inv = f;
    tick(); start = 1'b0;
  endtask

  task automatic pulse_result();
    tick(); res_tvalid = 1'b1; res_tready = 1'b1; res_tlast = 1'b1;
    tick(); res_tvalid = 1'b0; res_tready = 1'b0; res_tlast = 1'b0;
  endtask

  task automatic pulse_stop();
    tick(); stop = 1'b1;
    tick(); stop = 1'b0;
  endtask

  task automatic wait_q_empty(input string name, input int maxc);
    int i = 0;
    while (i < maxc && exp_q.size() != 0) begin sample(); i++; end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s: %0d beats still pending after %0d cycles, required 0", name, exp_q.size(), maxc);
      exp_q.delete();
    end
  endtask

  task automatic wait_done(input string name, input int maxc, output int cyc);
    int base = done_cnt;
    cyc = 0;
    while (cyc < maxc && done_cnt == base) begin sample(); cyc++; end
    if (done_cnt == base) begin
      checks++; errors++;
      $display("FAIL %s: no done within %0d cycles, required done", name, maxc);
    end
  endtask

  task automatic wait_beats(input string name, input int base, input int n);
    int i = 0;
    while (i < 200 && beats_seen - base < n) begin sample(); i++; end
    if (beats_seen - base < n) begin
      checks++; errors++;
      $display("FAIL %s: saw %0d beats, required %0d", name, beats_seen - base, n);
    end
  endtask

  int cyc, base, hi;

  initial begin
    ps_aresetn = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0; fwd_inv = 1'b0;
    nfft_log2 = 5'd0; s_axis_tvalid = 1'b1; m_axis_data_tready = 1'b1;
    m_axis_cfg_tready = 1'b1; res_tvalid = 1'b0; res_tready = 1'b0; res_tlast = 1'b0;
    ev_tlast_unexpected = 1'b0; ev_tlast_missing = 1'b0;

    // Reset state
    #3;
    check("rst_busy", 64'(busy), 0);
    check("rst_s_tready", 64'(s_axis_tready), 0);
    check("rst_m_tvalid", 64'(m_axis_data_tvalid), 0);
    check("rst_m_tlast", 64'(m_axis_data_tlast), 0);
    check("rst_cfg_tvalid", 64'(m_axis_cfg_tvalid), 0);
    check("rst_flags", 64'({done, cfg_err, seq_err, timeout_err}), 0);
    check("rst_frame_cnt", 64'(frame_cnt), 0);
    tick(); tick(); ps_aresetn = 1'b1;

    // Single shot, cfg held until ready
    m_axis_cfg_tready = 1'b0;
    cfg_q.push_back(16'h0106);
    push_frames(1, 64);
    do_start(5'd6, 1'b1);
    for (int i = 0; i < 3; i++) begin
      sample();
      check("t1_cfg_tvalid_hold", 64'(m_axis_cfg_tvalid), 1);
      check("t1_cfg_tdata_hold", 64'(m_axis_cfg_tdata), 64'h0106);
    end
    check("t1_busy", 64'(busy), 1);
    tick(); m_axis_cfg_tready = 1'b1;
    wait_q_empty("t1_beats", 200);
    base = done_cnt;
    sample();
    check("t1_busy_drain", 64'(busy), 1);
    check("t1_no_early_done", 64'(done_cnt - base), 0);
    pulse_result();
    wait_done("t1_done", 20, cyc);
    repeat (3) sample();
    check("t1_done_once", 64'(done_cnt - base), 1);
    check("t1_frame_cnt", 64'(frame_cnt), 1);
    check("t1_idle", 64'(busy), 0);

    // Invalid size, then a valid start clears cfg_err
    base = done_cnt;
    do_start(5'd13, 1'b0);
    sample();
    check("t2_cfg_err", 64'(cfg_err), 1);
    check("t2_busy", 64'(busy), 0);
    repeat (3) sample();
    check("t2_no_done", 64'(done_cnt - base), 0);
    cfg_q.push_back(16'h0003);
    push_frames(1, 8);
    do_start(5'd3, 1'b0);
    check("t2_cfg_err_clr", 64'(cfg_err), 0);
    wait_q_empty("t2_beats", 100);
    pulse_result();
    wait_done("t2_done", 20, cyc);
    check("t2_frame_cnt", 64'(frame_cnt), 1);

    // Continuous with backpressure; results withheld stall at four frames
    rand_rdy = 1'b1; continuous = 1'b1;
    cfg_q.push_back(16'h0103);
    push_frames(4, 8);
    do_start(5'd3, 1'b1);
    wait_q_empty("t3_four_frames", 600);
    hi = 0;
    for (int i = 0; i < 40; i++) begin sample(); if (s_axis_tready) hi++; end
    check("t3_gate_closed", 64'(hi), 0);
    check("t3_busy", 64'(busy), 1);
    base = done_cnt;
    push_frames(1, 8);
    pulse_result();
    pulse_stop();
    wait_q_empty("t3_fifth_frame", 200);
    for (int i = 0; i < 4; i++) pulse_result();
    wait_done("t3_done", 40, cyc);
    check("t3_frame_cnt", 64'(frame_cnt), 5);
    check("t3_no_timeout", 64'(timeout_err), 0);
    rand_rdy = 1'b0;

    // Stop mid-frame in continuous mode completes the frame only
    cfg_q.push_back(16'h0104);
    push_frames(1, 16);
    base = beats_seen;
    do_start(5'd4, 1'b1);
    wait_beats("t4_ten_beats", base, 10);
    pulse_stop();
    wait_q_empty("t4_beats", 100);
    repeat (30) sample();
    check("t4_frame_beats", 64'(beats_seen - base), 16);
    check("t4_busy", 64'(busy), 1);
    pulse_result();
    wait_done("t4_done", 20, cyc);
    check("t4_frame_cnt", 64'(frame_cnt), 1);
    continuous = 1'b0;

    // Drain timeout, late result, tlast event
    cfg_q.push_back(16'h0003);
    push_frames(1, 8);
    do_start(5'd3, 1'b0);
    wait_q_empty("t5_beats", 100);
    wait_done("t5_done", 200, cyc);
    check("t5_drain_cycles", 64'(cyc - 1), 100);
    check("t5_timeout_err", 64'(timeout_err), 1);
    check("t5_idle", 64'(busy), 0);
    check("t5_frame_cnt", 64'(frame_cnt), 0);
    pulse_result();
    sample();
    check("t5_late_result", 64'(frame_cnt), 1);
    tick(); ev_tlast_missing = 1'b1;
    tick(); ev_tlast_missing = 1'b0;
    sample();
    check("t5_seq_err", 64'(seq_err), 1);
    check("t5_timeout_sticky", 64'(timeout_err), 1);

    // Asynchronous reset at beat 5, then a clean frame
    cfg_q.push_back(16'h0104);
    push_frames(1, 16);
    base = beats_seen;
    do_start(5'd4, 1'b1);
    check("t6_start_clears_seq", 64'(seq_err), 0);
    tick(); ev_tlast_unexpected = 1'b1;
    tick(); ev_tlast_unexpected = 1'b0;
    wait_beats("t6_five_beats", base, 5);
    check("t6_seq_err", 64'(seq_err), 1);
    ps_aresetn = 1'b0;
    #1;
    check("t6_rst_busy", 64'(busy), 0);
    check("t6_rst_s_tready", 64'(s_axis_tready), 0);
    check("t6_rst_m_tvalid", 64'(m_axis_data_tvalid), 0);
    check("t6_rst_flags", 64'({done, cfg_err, seq_err, timeout_err}), 0);
    check("t6_rst_frame_cnt", 64'(frame_cnt), 0);
    exp_q.delete();
    cfg_q.delete();
    tick(); tick(); ps_aresetn = 1'b1;
    tick();
    exp_word = src_word;
    cfg_q.push_back(16'h0103);
    push_frames(1, 8);
    do_start(5'd3, 1'b1);
    wait_q_empty("t6_beats", 100);
    pulse_result();
    wait_done("t6_done", 20, cyc);
    check("t6_frame_cnt", 64'(frame_cnt), 1);
    check("t6_clean_flags", 64'({cfg_err, seq_err, timeout_err}), 0);

    repeat (5) sample();
    check("end_data_q_empty", 64'(exp_q.size()), 0);
    check("end_cfg_q_empty", 64'(cfg_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
